// File: rtl/btn_pkg.sv
// Shared encodings for the push-button conditioning blocks.
// State codes are fixed so state_dbg can be read directly on a logic analyser.
package btn_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE         = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_PRESS   = 3'd1;
  localparam logic [STATE_W-1:0] S_PULSE        = 3'd2;
  localparam logic [STATE_W-1:0] S_HELD         = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT_RELEASE = 3'd4;

endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchronizer for a raw asynchronous button pin.
// Both stages clear on reset, so a held button reads as released until sampled.
module btn_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces one push-button and emits a single stretched pulse per accepted press,
// long enough for logic on the slow move clock to sample every press exactly once.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int PULSE_CYCLES = 1048576,
  parameter int CNT_W        = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [7:0] press_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

  logic               sync;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [CNT_W-1:0]   cnt;
  logic               counting;
  logic               accept;

  btn_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync)
  );

  // Illegal codes fall into the default arm and recover to S_IDLE.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:         state_next = sync ? S_WAIT_PRESS : S_IDLE;
      S_WAIT_PRESS: begin
        if (!sync)             state_next = S_IDLE;
        else if (cnt == DB_LAST) state_next = S_PULSE;
        else                   state_next = S_WAIT_PRESS;
      end
      S_PULSE:        state_next = (cnt == PULSE_LAST) ? S_HELD : S_PULSE;
      S_HELD:         state_next = sync ? S_HELD : S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (sync)              state_next = S_HELD;
        else if (cnt == DB_LAST) state_next = S_IDLE;
        else                   state_next = S_WAIT_RELEASE;
      end
      default:        state_next = S_IDLE;
    endcase
  end

  assign counting = (state == S_WAIT_PRESS) || (state == S_PULSE) ||
                    (state == S_WAIT_RELEASE);
  assign accept   = (state == S_WAIT_PRESS) && sync && (cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One counter serves every timed state; any state change restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (counting) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= 8'd0;
    end else if (accept) begin
      press_count <= press_count + 8'd1;
    end
  end

  assign btn_pulse = (state == S_PULSE);
  assign btn_level = (state == S_PULSE) || (state == S_HELD) ||
                     (state == S_WAIT_RELEASE);
  assign state_dbg = state;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with short debounce/pulse timings.
// Reference model tracks run lengths of the synchronized input rather than FSM states.
module tb_btn_debounce_pulse;

  localparam int DB = 4;
  localparam int PL = 3;
  localparam int CW = 4;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       btn_pulse;
  logic [7:0] press_count;
  logic [2:0] state_dbg;

  int compared;
  int mismatched;

  // Model: mode 0 = released, 1 = pulsing, 2 = pressed
  int   m_mode;
  int   m_run;
  int   m_timer;
  int   m_count;
  logic m_d1;
  logic m_d2;

  btn_debounce_pulse #(
    .DB_CYCLES    (DB),
    .PULSE_CYCLES (PL),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .press_count (press_count),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode  = 0;
    m_run   = 0;
    m_timer = 0;
    m_count = 0;
    m_d1    = 1'b0;
    m_d2    = 1'b0;
  endtask

  // A press needs DB+1 consecutive high samples, a release DB+1 consecutive low ones.
  task automatic model_step();
    logic s;
    s    = m_d2;
    m_d2 = m_d1;
    m_d1 = btn_in;
    case (m_mode)
      0: begin
        m_run = s ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
          m_mode  = 1;
          m_timer = PL;
          m_run   = 0;
          m_count = (m_count + 1) % 256;
        end
      end
      1: begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin
          m_mode = 2;
          m_run  = 0;
        end
      end
      default: begin
        m_run = s ? 0 : m_run + 1;
        if (m_run == DB + 1) begin
          m_mode = 0;
          m_run  = 0;
        end
      end
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic b);
    btn_in = b;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1);
      compared++;
      if (btn_level !== 1'b0 || btn_pulse !== 1'b0 || press_count !== 8'd0 ||
          state_dbg !== 3'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cycle %0d: level=%b pulse=%b count=%0d state=%0d, required all 0",
                 i, btn_level, btn_pulse, press_count, state_dbg);
      end
    end
    cycle(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic exp_pulse;
    logic exp_level;
    reset_dut();
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b1);
      exp_pulse = (e >= 7 && e <= 9);
      exp_level = (e >= 7);
      compared++;
      if (btn_pulse !== exp_pulse || btn_level !== exp_level) begin
        mismatched++;
        $display("[TB] FAIL clean_press edge %0d: pulse=%b level=%b, required pulse=%b level=%b",
                 e, btn_pulse, btn_level, exp_pulse, exp_level);
      end
    end
    compared++;
    if (press_count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL clean_press_count: got %0d, required 1", press_count);
    end
    for (int e = 0; e < 10; e++) cycle(1'b0);
    compared++;
    if (btn_level !== 1'b0 || state_dbg !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL clean_release: level=%b state=%0d, required level=0 state=0",
               btn_level, state_dbg);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    int         saw_pulse;
    pattern   = 8'b1101_1000;
    saw_pulse = 0;
    reset_dut();
    for (int i = 7; i >= 0; i--) begin
      cycle(pattern[i]);
      if (btn_pulse) saw_pulse++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      if (btn_pulse) saw_pulse++;
    end
    compared++;
    if (saw_pulse != 0) begin
      mismatched++;
      $display("[TB] FAIL bounce_pulse: pulse seen %0d cycles, required 0", saw_pulse);
    end
    compared++;
    if (state_dbg !== 3'd0 || press_count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL bounce_state: state=%0d count=%0d, required state=0 count=0",
               state_dbg, press_count);
    end
  endtask

  task automatic test_release_glitch();
    logic [2:0] exp_state;
    reset_dut();
    for (int e = 1; e <= 12; e++) cycle(1'b1);
    for (int e = 13; e <= 20; e++) begin
      cycle((e == 13 || e == 14) ? 1'b0 : 1'b1);
      exp_state = (e == 15 || e == 16) ? 3'd4 : 3'd3;
      compared++;
      if (btn_level !== 1'b1 || btn_pulse !== 1'b0 || state_dbg !== exp_state) begin
        mismatched++;
        $display("[TB] FAIL release_glitch edge %0d: level=%b pulse=%b state=%0d, required 1/0/%0d",
                 e, btn_level, btn_pulse, state_dbg, exp_state);
      end
    end
    for (int j = 1; j <= 8; j++) begin
      cycle(1'b0);
      compared++;
      if (btn_level !== (j < 7)) begin
        mismatched++;
        $display("[TB] FAIL clean_release_latency step %0d: level=%b, required %b",
                 j, btn_level, (j < 7));
      end
    end
    compared++;
    if (press_count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL release_glitch_count: got %0d, required 1", press_count);
    end
  endtask

  task automatic test_release_in_pulse();
    logic [2:0] exp_state;
    int         pulses;
    pulses = 0;
    reset_dut();
    for (int e = 1; e <= 16; e++) begin
      cycle((e <= 7) ? 1'b1 : 1'b0);
      if (btn_pulse) pulses++;
      if (e <= 2)       exp_state = 3'd0;
      else if (e <= 6)  exp_state = 3'd1;
      else if (e <= 9)  exp_state = 3'd2;
      else if (e == 10) exp_state = 3'd3;
      else if (e <= 14) exp_state = 3'd4;
      else              exp_state = 3'd0;
      compared++;
      if (state_dbg !== exp_state) begin
        mismatched++;
        $display("[TB] FAIL release_in_pulse edge %0d: state=%0d, required %0d",
                 e, state_dbg, exp_state);
      end
    end
    compared++;
    if (pulses != PL || btn_level !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release_in_pulse_len: pulse cycles=%0d level=%b, required %0d and 0",
               pulses, btn_level, PL);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    reset_dut();
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b0);
      if (p == 255) begin
        compared++;
        if (press_count !== 8'd255) begin
          mismatched++;
          $display("[TB] FAIL wrap_255: got %0d, required 255", press_count);
        end
      end
    end
    compared++;
    if (press_count !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_256: got %0d, required 0", press_count);
    end
    for (int e = 1; e <= 8; e++) cycle(1'b1);
    compared++;
    if (btn_pulse !== 1'b1 || press_count !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL mid_pulse_setup: pulse=%b count=%0d, required 1 and 1",
               btn_pulse, press_count);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (btn_pulse !== 1'b0 || btn_level !== 1'b0 || press_count !== 8'd0 ||
        state_dbg !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: pulse=%b level=%b count=%0d state=%0d, required all 0",
               btn_pulse, btn_level, press_count, state_dbg);
    end
    btn_in = 1'b0;
    model_reset();
    @(negedge clk);
    cycle(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic lvl;
    int   len;
    reset_dut();
    for (int r = 0; r < 80; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        cycle(lvl);
        compared++;
        if (btn_pulse !== (m_mode == 1) || btn_level !== (m_mode != 0) ||
            press_count !== 8'(m_count)) begin
          mismatched++;
          $display("[TB] FAIL random run %0d: pulse=%b level=%b count=%0d, required %b/%b/%0d",
                   r, btn_pulse, btn_level, press_count, (m_mode == 1), (m_mode != 0), m_count);
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    btn_in     = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_release_in_pulse();
    test_wrap_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
